// File: rtl/sat_alu_pipe.sv
// sat_alu_pipe: elastic pipelined SIMD saturating add/sub unit.
// Results carry the scoreboard trans_id; sticky flag tracks saturation.
module sat_alu_pipe #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned LANES         = 1,
  parameter int unsigned STAGES        = 2,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          op_a_i,
  input  logic [XLEN-1:0]          op_b_i,
  input  logic [1:0]               mode_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [LANES-1:0]         ovf_o,
  output logic                     sticky_ovf_o,
  input  logic                     clr_sticky_i
);

  localparam int unsigned W = XLEN / LANES;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = ~SMAX;

  typedef struct packed {
    logic [XLEN-1:0]          res;
    logic [TRANS_ID_BITS-1:0] tid;
    logic [LANES-1:0]         ovf;
  } stage_t;

  stage_t            st_d;
  stage_t            st_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] down;

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic [W:0]   sum;
  logic [W:0]   dif;
  logic         sat;

  always_comb begin
    st_d     = '0;
    st_d.tid = trans_id_i;
    a   = '0;
    b   = '0;
    y   = '0;
    sum = '0;
    dif = '0;
    sat = 1'b0;
    for (int l = 0; l < int'(LANES); l++) begin
      a   = op_a_i[l*W +: W];
      b   = op_b_i[l*W +: W];
      sum = {1'b0, a} + {1'b0, b};
      dif = {1'b0, a} - {1'b0, b};
      unique case (1'b1)
        (mode_i == 2'b00): begin
          sat = (a[W-1] == b[W-1]) &&
                (sum[W-1] != a[W-1]);
          y   = sat ? (a[W-1] ? SMIN : SMAX)
                    : sum[W-1:0];
        end
        (mode_i == 2'b01): begin
          sat = (a[W-1] != b[W-1]) &&
                (dif[W-1] != a[W-1]);
          y   = sat ? (a[W-1] ? SMIN : SMAX)
                    : dif[W-1:0];
        end
        (mode_i == 2'b10): begin
          sat = sum[W];
          y   = sat ? '1 : sum[W-1:0];
        end
        default: begin
          sat = dif[W];
          y   = sat ? '0 : dif[W-1:0];
        end
      endcase
      st_d.res[l*W +: W] = y;
      st_d.ovf[l]        = sat;
    end
  end

  // down[k]: slot k can take a new entry this cycle
  always_comb begin
    down = '0;
    down[STAGES-1] = !vld_q[STAGES-1] || ready_i;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      down[k] = !vld_q[k] || down[k+1];
    end
  end

  assign ready_o = down[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        st_q[k] <= '0;
      end
    end else begin
      if (flush_i) begin
        vld_q[0] <= 1'b0;
      end else if (down[0]) begin
        vld_q[0] <= valid_i;
      end
      if (valid_i && down[0]) begin
        st_q[0] <= st_d;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (flush_i) begin
          vld_q[k] <= 1'b0;
        end else if (down[k]) begin
          vld_q[k] <= vld_q[k-1];
        end
        if (down[k] && vld_q[k-1]) begin
          st_q[k] <= st_q[k-1];
        end
      end
    end
  end

  assign valid_o    = vld_q[STAGES-1];
  assign result_o   = st_q[STAGES-1].res;
  assign trans_id_o = st_q[STAGES-1].tid;
  assign ovf_o      = st_q[STAGES-1].ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_ovf_o <= 1'b0;
    end else if (valid_o && ready_i && |ovf_o) begin
      sticky_ovf_o <= 1'b1;
    end else if (clr_sticky_i) begin
      sticky_ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_alu_pipe.sv
// tb_sat_alu_pipe: directed + random checks of sat_alu_pipe
// against a clamp-based arithmetic model and in-order scoreboard.
module tb_sat_alu_pipe;

  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        vld_i;
  logic        rdy_i;
  logic        clr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  mode;
  logic [2:0]  tid;

  logic        rdy1, rdy4, vo1, vo4, stk1, stk4;
  logic [31:0] res1, res4;
  logic [2:0]  tido1, tido4;
  logic [0:0]  ovf1;
  logic [3:0]  ovf4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sat_alu_pipe #(
    .XLEN(32), .LANES(1), .STAGES(STAGES), .TRANS_ID_BITS(3)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(vld_i), .ready_o(rdy1),
    .op_a_i(op_a), .op_b_i(op_b), .mode_i(mode),
    .trans_id_i(tid), .valid_o(vo1), .ready_i(rdy_i),
    .result_o(res1), .trans_id_o(tido1), .ovf_o(ovf1),
    .sticky_ovf_o(stk1), .clr_sticky_i(clr)
  );

  sat_alu_pipe #(
    .XLEN(32), .LANES(4), .STAGES(STAGES), .TRANS_ID_BITS(3)
  ) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(vld_i), .ready_o(rdy4),
    .op_a_i(op_a), .op_b_i(op_b), .mode_i(mode),
    .trans_id_i(tid), .valid_o(vo4), .ready_i(rdy_i),
    .result_o(res4), .trans_id_o(tido4), .ovf_o(ovf4),
    .sticky_ovf_o(stk4), .clr_sticky_i(clr)
  );

  typedef struct {
    logic [2:0]  id;
    logic [31:0] r1;
    logic        o1;
    logic [31:0] r4;
    logic [3:0]  o4;
  } exp_t;

  exp_t q[$];
  logic m_stk1 = 1'b0;
  logic m_stk4 = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // exact per-lane arithmetic, then clamp to the lane's range
  function automatic void ref_op(
    input  logic [31:0] a, input logic [31:0] b,
    input  logic [1:0] m, input int lanes,
    output logic [31:0] r, output logic [3:0] ov);
    int w;
    longint x, y, v, lo, hi, msk;
    w   = 32 / lanes;
    msk = (longint'(1) << w) - 1;
    r   = '0;
    ov  = '0;
    for (int l = 0; l < lanes; l++) begin
      x = (longint'(a) >> (l * w)) & msk;
      y = (longint'(b) >> (l * w)) & msk;
      if (!m[1]) begin
        if (x >= (longint'(1) << (w - 1))) x -= (msk + 1);
        if (y >= (longint'(1) << (w - 1))) y -= (msk + 1);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
      end else begin
        lo = 0;
        hi = msk;
      end
      v = m[0] ? x - y : x + y;
      if (v > hi) begin
        v = hi; ov[l] = 1'b1;
      end else if (v < lo) begin
        v = lo; ov[l] = 1'b1;
      end
      r = r | 32'((v & msk) << (l * w));
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ov;
    logic [31:0] r;
    if (!rst_n) begin
      q.delete();
      m_stk1 = 1'b0;
      m_stk4 = 1'b0;
    end else begin
      chk("stk1", stk1, m_stk1);
      chk("stk4", stk4, m_stk4);
      if (vo1 || vo4) begin
        if (q.size() == 0) begin
          chk("spurious", {vo1, vo4}, 0);
        end else begin
          e = q[0];
          chk("vo1", vo1, 1);
          chk("vo4", vo4, 1);
          chk("id1", tido1, e.id);
          chk("id4", tido4, e.id);
          chk("res1", res1, e.r1);
          chk("ovf1", ovf1, e.o1);
          chk("res4", res4, e.r4);
          chk("ovf4", ovf4, e.o4);
        end
      end
      if (vo1 && rdy_i && q.size() > 0) begin
        e = q.pop_front();
        m_stk1 = e.o1 ? 1'b1 : (clr ? 1'b0 : m_stk1);
        m_stk4 = |e.o4 ? 1'b1 : (clr ? 1'b0 : m_stk4);
      end else if (clr) begin
        m_stk1 = 1'b0;
        m_stk4 = 1'b0;
      end
      if (flush) begin
        q.delete();
      end else if (vld_i && rdy1) begin
        e.id = tid;
        ref_op(op_a, op_b, mode, 1, r, ov);
        e.r1 = r;
        e.o1 = ov[0];
        ref_op(op_a, op_b, mode, 4, r, ov);
        e.r4 = r;
        e.o4 = ov;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [1:0] m,
                       input logic [2:0] id);
    op_a  = a;
    op_b  = b;
    mode  = m;
    tid   = id;
    vld_i = 1'b1;
    #1 chk("rdy", rdy1, 1);
    @(posedge clk);
    #1 vld_i = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!vo1 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("lat", n + 1, STAGES);
  endtask

  function automatic logic [31:0] pick();
    logic [7:0] bt;
    bt = 8'($urandom_range(0, 3) * 8'h40 - 8'($urandom_range(0, 1)));
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return {4{bt}};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    vld_i = 1'b0;
    rdy_i = 1'b1;
    clr   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    mode  = '0;
    tid   = '0;
    #1;
    chk("rst_vo", vo1, 0);
    chk("rst_res", res1, 0);
    chk("rst_id", tido1, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_stk", stk1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst_rdy", rdy1, 1);

    drive(32'h7FFF_FFFF, 32'h1, 2'b00, 3'd1);
    wait_out();
    chk("t1_res", res1, 32'h7FFF_FFFF);
    chk("t1_ovf", ovf1, 1);
    @(posedge clk);
    #1 chk("t1_stk", stk1, 1);

    drive(32'h8000_0000, 32'h1, 2'b01, 3'd2);
    wait_out();
    chk("t2_res", res1, 32'h8000_0000);
    chk("t2_ovf", ovf1, 1);
    drive(32'hFFFF_FFFF, 32'h1, 2'b00, 3'd3);
    wait_out();
    chk("t2b_res", res1, 32'h0);
    chk("t2b_ovf", ovf1, 0);

    drive(32'hFFFF_FFF0, 32'h20, 2'b10, 3'd4);
    wait_out();
    chk("t3_res", res1, 32'hFFFF_FFFF);
    chk("t3_ovf", ovf1, 1);
    drive(32'h1005_FF00, 32'h2003_0100, 2'b11, 3'd5);
    wait_out();
    chk("t3_res4", res4, 32'h0002_FE00);
    chk("t3_ovf4", ovf4, 4'b1000);
    chk("t3_res1", res1, 32'h0);

    repeat (3) @(posedge clk);
    #1 rdy_i = 1'b0;
    vld_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tid  = 3'(i);
      op_a = pick();
      op_b = pick();
      mode = 2'($urandom);
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    chk("stall_rdy", rdy1, 0);
    repeat (3) @(posedge clk);
    #1 chk("stall_rdy2", rdy1, 0);
    chk("stall_id", tido1, 1);
    rdy_i = 1'b1;
    #1 chk("stall_rel", rdy1, 1);
    @(posedge clk);
    #1 vld_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("stall_drain", q.size(), 0);

    vld_i = 1'b1;
    tid   = 3'd4;
    @(posedge clk);
    #1 tid = 3'd5;
    @(posedge clk);
    #1 tid = 3'd6;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    vld_i = 1'b0;
    chk("flush_vo", vo1, 0);
    @(posedge clk);
    #1 chk("flush_empty", vo1, 0);
    drive(32'h1234_5678, 32'h1111_1111, 2'b10, 3'd7);
    wait_out();
    chk("flush_id", tido1, 7);

    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr0", stk1, 0);
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 3'd1);
    wait_out();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("set_wins", stk1, 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr_only", stk1, 0);

    for (int c = 0; c < 400; c++) begin
      vld_i = ($urandom_range(0, 3) != 0);
      rdy_i = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      mode  = 2'($urandom);
      tid   = 3'($urandom);
      op_a  = pick();
      op_b  = pick();
      @(posedge clk);
      #1;
    end
    vld_i = 1'b0;
    rdy_i = 1'b1;
    flush = 1'b0;
    clr   = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rand_drain", q.size(), 0);

    vld_i = 1'b1;
    op_a  = 32'h7FFF_FFFF;
    op_b  = 32'h0000_0001;
    mode  = 2'b00;
    tid   = 3'd5;
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_stk", stk1, 1);
    chk("pre_rst_vo", vo1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vo", vo1, 0);
    chk("mid_rst_res", res1, 0);
    chk("mid_rst_id", tido1, 0);
    chk("mid_rst_ovf", ovf1, 0);
    chk("mid_rst_stk", stk1, 0);
    chk("mid_rst_res4", res4, 0);
    vld_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
